// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 definitions for the ASCII-to-scancode transmit path:
// scancode constants, the transmit FSM state type and a letter lookup helper.
package ps2_pkg;

    // Modifier, prefix and control keys
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_TAB      = 8'h0D;

    // Punctuation keys (unshifted legends)
    localparam logic [7:0] SC_BACKTICK = 8'h0E;
    localparam logic [7:0] SC_MINUS    = 8'h4E;
    localparam logic [7:0] SC_EQUAL    = 8'h55;
    localparam logic [7:0] SC_BSLASH   = 8'h5D;

    // Digit row
    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    // Letter keys
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

    // Make/break sequencing states: shift make, key make, key break, shift break
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SH_MK  = 3'd1,
        KEY_MK = 3'd2,
        KB_F0  = 3'd3,
        KB     = 3'd4,
        SB_F0  = 3'd5,
        SB     = 3'd6
    } tx_state_t;

    // Letter index 0..25 (a..z) to key code; both cases share the same key
    function automatic logic [7:0] letter_code(input logic [4:0] idx);
        logic [7:0] c;
        case (idx)
            5'd0:  c = SC_A;
            5'd1:  c = SC_B;
            5'd2:  c = SC_C;
            5'd3:  c = SC_D;
            5'd4:  c = SC_E;
            5'd5:  c = SC_F;
            5'd6:  c = SC_G;
            5'd7:  c = SC_H;
            5'd8:  c = SC_I;
            5'd9:  c = SC_J;
            5'd10: c = SC_K;
            5'd11: c = SC_L;
            5'd12: c = SC_M;
            5'd13: c = SC_N;
            5'd14: c = SC_O;
            5'd15: c = SC_P;
            5'd16: c = SC_Q;
            5'd17: c = SC_R;
            5'd18: c = SC_S;
            5'd19: c = SC_T;
            5'd20: c = SC_U;
            5'd21: c = SC_V;
            5'd22: c = SC_W;
            5'd23: c = SC_X;
            5'd24: c = SC_Y;
            5'd25: c = SC_Z;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ascii_scancode_lut.sv
// Combinational ASCII to PS/2 Set-2 key lookup.
// Reports whether the character is typeable, whether Left Shift must wrap it,
// and the base key code. Shifted punctuation (!@#$%^&*()~_+|) is only
// recognised when ASCII_SCANCODE_SHIFT_SYMBOLS_EN is defined.
import ps2_pkg::*;

module ascii_scancode_lut (
    input  logic [7:0] in_ascii,
    output logic       supported,
    output logic       needs_shift,
    output logic [7:0] code
);

    // Letters map by their low five bits (a/A = 1 .. z/Z = 26); everything else by table
    always_comb begin
        supported   = 1'b0;
        needs_shift = 1'b0;
        code        = 8'h00;
        if (in_ascii >= 8'h61 && in_ascii <= 8'h7A) begin
            supported = 1'b1;
            code      = letter_code(in_ascii[4:0] - 5'd1);
        end else if (in_ascii >= 8'h41 && in_ascii <= 8'h5A) begin
            supported   = 1'b1;
            needs_shift = 1'b1;
            code        = letter_code(in_ascii[4:0] - 5'd1);
        end else begin
            case (in_ascii)
                8'h30: begin supported = 1'b1; code = SC_0; end
                8'h31: begin supported = 1'b1; code = SC_1; end
                8'h32: begin supported = 1'b1; code = SC_2; end
                8'h33: begin supported = 1'b1; code = SC_3; end
                8'h34: begin supported = 1'b1; code = SC_4; end
                8'h35: begin supported = 1'b1; code = SC_5; end
                8'h36: begin supported = 1'b1; code = SC_6; end
                8'h37: begin supported = 1'b1; code = SC_7; end
                8'h38: begin supported = 1'b1; code = SC_8; end
                8'h39: begin supported = 1'b1; code = SC_9; end
                8'h60: begin supported = 1'b1; code = SC_BACKTICK; end
                8'h2D: begin supported = 1'b1; code = SC_MINUS; end
                8'h3D: begin supported = 1'b1; code = SC_EQUAL; end
                8'h5C: begin supported = 1'b1; code = SC_BSLASH; end
                8'h08: begin supported = 1'b1; code = SC_BKSP; end
                8'h20: begin supported = 1'b1; code = SC_SPACE; end
                8'h09: begin supported = 1'b1; code = SC_TAB; end
`ifdef ASCII_SCANCODE_SHIFT_SYMBOLS_EN
                8'h21: begin supported = 1'b1; needs_shift = 1'b1; code = SC_1; end
                8'h40: begin supported = 1'b1; needs_shift = 1'b1; code = SC_2; end
                8'h23: begin supported = 1'b1; needs_shift = 1'b1; code = SC_3; end
                8'h24: begin supported = 1'b1; needs_shift = 1'b1; code = SC_4; end
                8'h25: begin supported = 1'b1; needs_shift = 1'b1; code = SC_5; end
                8'h5E: begin supported = 1'b1; needs_shift = 1'b1; code = SC_6; end
                8'h26: begin supported = 1'b1; needs_shift = 1'b1; code = SC_7; end
                8'h2A: begin supported = 1'b1; needs_shift = 1'b1; code = SC_8; end
                8'h28: begin supported = 1'b1; needs_shift = 1'b1; code = SC_9; end
                8'h29: begin supported = 1'b1; needs_shift = 1'b1; code = SC_0; end
                8'h7E: begin supported = 1'b1; needs_shift = 1'b1; code = SC_BACKTICK; end
                8'h5F: begin supported = 1'b1; needs_shift = 1'b1; code = SC_MINUS; end
                8'h2B: begin supported = 1'b1; needs_shift = 1'b1; code = SC_EQUAL; end
                8'h7C: begin supported = 1'b1; needs_shift = 1'b1; code = SC_BSLASH; end
`endif
                default: begin
                    supported   = 1'b0;
                    needs_shift = 1'b0;
                    code        = 8'h00;
                end
            endcase
        end
    end

endmodule

// File: rtl/ascii_scancode_tx.sv
// ASCII character to PS/2 Set-2 make/break byte sequence generator.
// Accepts one character when idle, then streams shift-make (optional), key
// make, key break and shift break (optional) under a valid/ready handshake.
// Shifted punctuation support is enabled with ASCII_SCANCODE_SHIFT_SYMBOLS_EN
// (handled entirely inside ascii_scancode_lut).
import ps2_pkg::*;

module ascii_scancode_tx #(
    parameter logic [7:0] SHIFT_CODE   = SC_LSHIFT,
    parameter logic [7:0] BREAK_PREFIX = SC_BREAK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_ascii,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_scan,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       error
);

    tx_state_t  state;
    tx_state_t  next_state;
    logic [7:0] code_q;
    logic       shift_q;
    logic       error_q;

    logic       lut_supported;
    logic       lut_shift;
    logic [7:0] lut_code;
    logic       accept;

    ascii_scancode_lut u_lut (
        .in_ascii    (in_ascii),
        .supported   (lut_supported),
        .needs_shift (lut_shift),
        .code        (lut_code)
    );

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign error    = error_q;

    // State register, character latch and the one-cycle drop indication
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            code_q  <= 8'h00;
            shift_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= next_state;
            error_q <= accept && !lut_supported;
            if (accept && lut_supported) begin
                code_q  <= lut_code;
                shift_q <= lut_shift;
            end
        end
    end

    // Byte selection per state; a state only advances once its byte is taken
    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_scan   = 8'h00;
        case (state)
            IDLE: begin
                if (accept && lut_supported) begin
                    next_state = lut_shift ? SH_MK : KEY_MK;
                end
            end
            SH_MK: begin
                out_valid = 1'b1;
                out_scan  = SHIFT_CODE;
                if (out_ready) next_state = KEY_MK;
            end
            KEY_MK: begin
                out_valid = 1'b1;
                out_scan  = code_q;
                if (out_ready) next_state = KB_F0;
            end
            KB_F0: begin
                out_valid = 1'b1;
                out_scan  = BREAK_PREFIX;
                if (out_ready) next_state = KB;
            end
            KB: begin
                out_valid = 1'b1;
                out_scan  = code_q;
                if (out_ready) next_state = shift_q ? SB_F0 : IDLE;
            end
            SB_F0: begin
                out_valid = 1'b1;
                out_scan  = BREAK_PREFIX;
                if (out_ready) next_state = SB;
            end
            SB: begin
                out_valid = 1'b1;
                out_scan  = SHIFT_CODE;
                if (out_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
